// File: rtl/hwpe_stream_streamer_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_streamer_req_fifo
// Description : Queues controller transfer requests and issues them to a
//               streamer one at a time, waiting for each done.
// Revision    : 1.0 - initial release
// ============================================================================

package hwpe_stream_streamer_req_fifo_pkg;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] trans_size;
        logic [15:0] line_stride;
        logic [15:0] line_length;
        logic [15:0] feat_stride;
        logic [15:0] feat_length;
        logic [15:0] step;
    } ctrl_addressgen_t;

    typedef struct packed {
        logic             req_start;
        ctrl_addressgen_t addressgen_ctrl;
    } ctrl_sourcesink_t;

    typedef struct packed {
        logic ready_start;
        logic done;
        logic ready_fifo;
    } flags_sourcesink_t;

endpackage

module hwpe_stream_streamer_req_fifo
    import hwpe_stream_streamer_req_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     test_mode_i,
    input  logic                     clear_i,
    input  ctrl_sourcesink_t         controller_ctrl_i,
    output flags_sourcesink_t        controller_flags_o,
    output ctrl_sourcesink_t         streamer_ctrl_o,
    input  flags_sourcesink_t        streamer_flags_i,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     idle_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    ctrl_addressgen_t   r_mem [DEPTH];
    ctrl_addressgen_t   r_last;

    logic w_ready;
    logic w_push;
    logic w_issue;
    logic w_unused_test_mode;

    assign w_unused_test_mode = test_mode_i;

    // A clear cycle suppresses both sides so the flush wins unambiguously.
    assign w_ready = (r_count != CNT_W'(DEPTH));
    assign w_push  = controller_ctrl_i.req_start && w_ready && !clear_i;
    assign w_issue = (r_state == IDLE) && (r_count != '0) &&
                     streamer_flags_i.ready_start && !clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_issue) begin
                r_head  <= r_head + PTR_W'(1);
                r_last  <= r_mem[r_head];
                r_state <= BUSY;
            end else if ((r_state == BUSY) && streamer_flags_i.done) begin
                r_state <= IDLE;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_tail] <= controller_ctrl_i.addressgen_ctrl;
        end
    end

    always_comb begin
        streamer_ctrl_o                 = controller_ctrl_i;
        streamer_ctrl_o.req_start       = w_issue;
        streamer_ctrl_o.addressgen_ctrl = w_issue ? r_mem[r_head] : r_last;

        controller_flags_o             = streamer_flags_i;
        controller_flags_o.ready_start = w_ready;
        controller_flags_o.done        = streamer_flags_i.done && (r_state == BUSY);
    end

    assign pending_o = r_count;
    assign idle_o    = (r_count == '0) && (r_state == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_streamer_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_stream_streamer_req_fifo
// Description : Queue-model checked bench for the streamer request FIFO.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_hwpe_stream_streamer_req_fifo;
    import hwpe_stream_streamer_req_fifo_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic              clk;
    logic              rst_n;
    logic              test_mode;
    logic              clear;
    ctrl_sourcesink_t  cctrl;
    flags_sourcesink_t cflags;
    ctrl_sourcesink_t  sctrl;
    flags_sourcesink_t sflags;
    logic [$clog2(DEPTH):0] pending;
    logic              idle;

    int checks = 0;
    int errors = 0;

    hwpe_stream_streamer_req_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .test_mode_i        (test_mode),
        .clear_i            (clear),
        .controller_ctrl_i  (cctrl),
        .controller_flags_o (cflags),
        .streamer_ctrl_o    (sctrl),
        .streamer_flags_i   (sflags),
        .pending_o          (pending),
        .idle_o             (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a plain queue of requests, a busy bit, and the last issued request.
    ctrl_addressgen_t mq[$];
    bit               m_busy;
    ctrl_addressgen_t m_last;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_issue();
        return !m_busy && (mq.size() != 0) && sflags.ready_start && !clear;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_busy = 0;
            m_last = '0;
        end else if (clear) begin
            mq.delete();
            m_busy = 0;
            m_last = '0;
        end else begin
            bit iss;
            bit psh;
            iss = m_issue();
            psh = cctrl.req_start && (mq.size() != DEPTH);
            if (iss) begin
                m_last = mq.pop_front();
                m_busy = 1;
            end else if (m_busy && sflags.done) begin
                m_busy = 0;
            end
            if (psh) mq.push_back(cctrl.addressgen_ctrl);
        end
    end

    always @(negedge clk) begin
        bit               e_iss;
        ctrl_addressgen_t e_addr;
        e_iss  = m_issue();
        e_addr = e_iss ? mq[0] : m_last;
        chk("req_start", sctrl.req_start, e_iss);
        chk("addressgen", sctrl.addressgen_ctrl, e_addr);
        chk("ready_start", cflags.ready_start, mq.size() != DEPTH);
        chk("ctrl_done", cflags.done, sflags.done && m_busy);
        chk("ready_fifo", cflags.ready_fifo, sflags.ready_fifo);
        chk("pending", pending, mq.size());
        chk("idle", idle, (mq.size() == 0) && !m_busy);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] base, input logic [31:0] size);
        cctrl.req_start                  = 1'b1;
        cctrl.addressgen_ctrl            = '0;
        cctrl.addressgen_ctrl.base_addr  = base;
        cctrl.addressgen_ctrl.trans_size = size;
    endtask

    initial begin
        rst_n     = 1'b0;
        test_mode = 1'b0;
        clear     = 1'b0;
        cctrl     = '0;
        sflags    = '0;

        @(negedge clk);
        chk("rst_ready", cflags.ready_start, 1'b1);
        chk("rst_pending", pending, 0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_req", sctrl.req_start, 1'b0);
        step();
        rst_n = 1'b1;

        // Single request
        step();
        sflags.ready_start = 1'b1;
        push(32'h100, 32'd16);
        @(negedge clk);
        chk("s1_no_bypass", sctrl.req_start, 1'b0);
        step();
        cctrl.req_start = 1'b0;
        @(negedge clk);
        chk("s1_issue", sctrl.req_start, 1'b1);
        chk("s1_addr", sctrl.addressgen_ctrl.base_addr, 32'h100);
        step();
        @(negedge clk);
        chk("s1_busy", idle, 1'b0);
        step();
        sflags.done = 1'b1;
        @(negedge clk);
        chk("s1_done", cflags.done, 1'b1);
        step();
        sflags.done = 1'b0;
        @(negedge clk);
        chk("s1_idle", idle, 1'b1);

        // Fill with streamer stalled, third push dropped
        step();
        sflags.ready_start = 1'b0;
        push(32'h100, 32'd16);
        step();
        push(32'h200, 32'd16);
        step();
        push(32'h300, 32'd16);
        @(negedge clk);
        chk("s2_full", cflags.ready_start, 1'b0);
        step();
        cctrl.req_start = 1'b0;
        @(negedge clk);
        chk("s2_pending", pending, 2);
        step();
        sflags.ready_start = 1'b1;
        @(negedge clk);
        chk("s2_issue1", sctrl.addressgen_ctrl.base_addr, 32'h100);
        step();
        @(negedge clk);
        chk("s2_hold_a", sctrl.addressgen_ctrl.base_addr, 32'h100);
        step();
        @(negedge clk);
        chk("s2_hold_b", sctrl.addressgen_ctrl.base_addr, 32'h100);
        step();
        sflags.done = 1'b1;
        step();
        sflags.done = 1'b0;
        @(negedge clk);
        chk("s2_b2b_req", sctrl.req_start, 1'b1);
        chk("s2_b2b_addr", sctrl.addressgen_ctrl.base_addr, 32'h200);
        step();
        sflags.done = 1'b1;
        step();
        sflags.done = 1'b0;
        @(negedge clk);
        chk("s2_drained", pending, 0);

        // Simultaneous push and pop across pointer wrap
        step();
        sflags.ready_start = 1'b0;
        push(32'h1000, 32'd8);
        step();
        cctrl.req_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            sflags.done        = 1'b0;
            sflags.ready_start = 1'b1;
            push(32'h1000 + i, 32'd8);
            @(negedge clk);
            chk("s3_order", sctrl.addressgen_ctrl.base_addr, 32'h1000 + i - 1);
            step();
            cctrl.req_start = 1'b0;
            sflags.done     = 1'b1;
            @(negedge clk);
            chk("s3_count", pending, 1);
        end
        step();
        sflags.done = 1'b0;
        @(negedge clk);
        chk("s3_last", sctrl.addressgen_ctrl.base_addr, 32'h1005);
        step();
        sflags.done = 1'b1;
        step();
        sflags.done = 1'b0;

        // Clear while busy with one pending
        step();
        push(32'h2000, 32'd4);
        step();
        push(32'h2100, 32'd4);
        step();
        cctrl.req_start = 1'b0;
        @(negedge clk);
        chk("s4_pending", pending, 1);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        chk("s4_pending0", pending, 0);
        chk("s4_idle", idle, 1'b1);
        chk("s4_noreq", sctrl.req_start, 1'b0);
        step();
        sflags.done = 1'b1;
        @(negedge clk);
        chk("s4_nodone", cflags.done, 1'b0);
        step();
        sflags.done = 1'b0;

        // Asynchronous reset mid-transfer
        step();
        push(32'h3000, 32'd4);
        step();
        cctrl.req_start = 1'b0;
        step();
        #2;
        rst_n       = 1'b0;
        sflags.done = 1'b1;
        @(negedge clk);
        chk("s5_req", sctrl.req_start, 1'b0);
        chk("s5_addr", sctrl.addressgen_ctrl, 0);
        chk("s5_ready", cflags.ready_start, 1'b1);
        chk("s5_idle", idle, 1'b1);
        chk("s5_done", cflags.done, 1'b0);
        step();
        rst_n       = 1'b1;
        sflags.done = 1'b0;
        push(32'h4000, 32'd4);
        step();
        cctrl.req_start = 1'b0;
        @(negedge clk);
        chk("s5_issue", sctrl.addressgen_ctrl.base_addr, 32'h4000);
        step();
        sflags.done = 1'b1;
        step();
        sflags.done = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            cctrl.req_start                   = 1'($urandom_range(0, 1));
            cctrl.addressgen_ctrl.base_addr   = $urandom();
            cctrl.addressgen_ctrl.trans_size  = $urandom();
            cctrl.addressgen_ctrl.line_stride = 16'($urandom());
            cctrl.addressgen_ctrl.step        = 16'($urandom());
            sflags.ready_start                = ($urandom() % 4) != 0;
            sflags.done                       = ($urandom() % 3) == 0;
            sflags.ready_fifo                 = 1'($urandom_range(0, 1));
            clear                             = ($urandom() % 50) == 0;
            test_mode                         = 1'($urandom_range(0, 1));
        end
        step();
        cctrl  = '0;
        sflags = '0;
        clear  = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
